// File: rtl/cmip_pkg.sv
// Shared definitions for the pulse-CDC arbiter: FSM state encoding and
// the legality rule for the minimum pulse spacing.
package cmip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Spacing below two cycles would let o_pulse stay high back-to-back,
    // and the toggle synchronizer downstream could then merge two events.
    localparam int GAP_CYC_MIN = 2;

    function automatic bit gap_cyc_legal(input int gap_cyc);
        return gap_cyc >= GAP_CYC_MIN;
    endfunction

endpackage

// File: rtl/cmip_rr_pick.sv
// Combinational round-robin picker. It returns the first requesting channel
// found when searching upward from ptr and wrapping around at CH_NUM-1.
module cmip_rr_pick
    import cmip_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int ID_W   = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic              valid,
    output logic [ID_W-1:0]   idx
);

    // Pass one covers channels at or above ptr. Pass two wraps around to the low channels.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (!valid && req[k] && (ID_W'(k) >= ptr)) begin
                valid = 1'b1;
                idx   = ID_W'(k);
            end
        end
        for (int k = 0; k < CH_NUM; k++) begin
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/cmip_pulse_arb.sv
// Round-robin scheduler in front of a single toggle-based pulse synchronizer.
// It counts request edges per channel, grants one channel at a time, and
// keeps issued pulses at least GAP_CYC source cycles apart.
module cmip_pulse_arb
    import cmip_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int ID_W    = $clog2(CH_NUM),
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CH_NUM-1:0] i_req_pulse,
    input  logic              i_enable,
    input  logic              i_clr_ovf,
    output logic              o_pulse,
    output logic [ID_W-1:0]   o_pulse_id,
    output logic              o_busy,
    output logic [CH_NUM-1:0] o_pend,
    output logic [CH_NUM-1:0] o_ovf
);

    localparam int                GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYC - 2);
    localparam logic [ID_W-1:0]   LAST_CH  = ID_W'(CH_NUM - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    generate
        if (!gap_cyc_legal(GAP_CYC)) begin : g_gap_cyc_illegal
            $error("cmip_pulse_arb: GAP_CYC must be at least 2");
        end
    endgenerate

    arb_state_t        state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   start_ptr;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_valid;
    logic              grant;

    logic [CH_NUM-1:0] req_d1;
    logic [CH_NUM-1:0] evt;
    logic [CH_NUM-1:0] pend;
    logic [CH_NUM-1:0] dec;
    logic [CH_NUM-1:0] set_ovf;
    logic [CNT_W-1:0]  cnt     [CH_NUM];
    logic [CNT_W-1:0]  cnt_nxt [CH_NUM];

    assign evt = i_req_pulse & ~req_d1;

    // The search begins one past the last winner, so a busy channel cannot starve the others.
    assign start_ptr = (last_grant == LAST_CH) ? '0 : last_grant + ID_W'(1);

    // A grant happens only where the FSM may start a pulse: in IDLE, or at the end of a GAP.
    assign grant = i_enable && pick_valid &&
                   ((state == IDLE) || ((state == GAP) && (gap_cnt == '0)));

    assign dec = grant ? (CH_NUM'(1) << pick_idx) : '0;

    // Build the per-channel "has work" vector that the picker searches.
    always_comb begin
        pend = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            pend[k] = (cnt[k] != '0);
        end
    end

    cmip_rr_pick #(
        .CH_NUM (CH_NUM),
        .ID_W   (ID_W)
    ) u_pick (
        .req   (pend),
        .ptr   (start_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next count per channel. If an edge and a grant arrive together they cancel, and no overflow is raised.
    always_comb begin
        set_ovf = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            cnt_nxt[k] = cnt[k];
            if (evt[k] && !dec[k]) begin
                if (cnt[k] == CNT_MAX) begin
                    set_ovf[k] = 1'b1;
                end else begin
                    cnt_nxt[k] = cnt[k] + 1'b1;
                end
            end else if (dec[k] && !evt[k]) begin
                cnt_nxt[k] = cnt[k] - 1'b1;
            end
        end
    end

    // Edge-detect history, pending counters, and the registered pend/ovf flags. A new overflow beats a clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            req_d1 <= '0;
            o_pend <= '0;
            o_ovf  <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            req_d1 <= i_req_pulse;
            for (int k = 0; k < CH_NUM; k++) begin
                cnt[k]    <= cnt_nxt[k];
                o_pend[k] <= (cnt_nxt[k] != '0);
            end
            o_ovf <= set_ovf | (o_ovf & {CH_NUM{~i_clr_ovf}});
        end
    end

    // Issue FSM: a one-cycle pulse, then a GAP countdown, and it chains straight into the next grant while work remains.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            last_grant <= LAST_CH;
            o_pulse    <= 1'b0;
            o_pulse_id <= '0;
            o_busy     <= 1'b0;
        end else begin
            o_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= ISSUE;
                        o_pulse    <= 1'b1;
                        o_pulse_id <= pick_idx;
                        last_grant <= pick_idx;
                        o_busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    gap_cnt <= GAP_LOAD;
                    state   <= GAP;
                    o_busy  <= 1'b1;
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (grant) begin
                        state      <= ISSUE;
                        o_pulse    <= 1'b1;
                        o_pulse_id <= pick_idx;
                        last_grant <= pick_idx;
                        o_busy     <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmip_pulse_arb.sv
// Directed testbench for cmip_pulse_arb. It uses CH_NUM=4, CNT_W=2 and GAP_CYC=8,
// and every expected value below was worked out by hand.
module tb_cmip_pulse_arb;

    localparam int CH_NUM  = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 2;
    localparam int GAP_CYC = 8;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [CH_NUM-1:0] i_req_pulse;
    logic              i_enable;
    logic              i_clr_ovf;
    logic              o_pulse;
    logic [ID_W-1:0]   o_pulse_id;
    logic              o_busy;
    logic [CH_NUM-1:0] o_pend;
    logic [CH_NUM-1:0] o_ovf;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int e0          = 0;
    int busy_cnt    = 0;
    int pulse_cyc[$];
    int pulse_id[$];

    // Free-running source clock.
    always #5 i_clk = ~i_clk;

    cmip_pulse_arb #(
        .CH_NUM  (CH_NUM),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_pulse (i_req_pulse),
        .i_enable    (i_enable),
        .i_clr_ovf   (i_clr_ovf),
        .o_pulse     (o_pulse),
        .o_pulse_id  (o_pulse_id),
        .o_busy      (o_busy),
        .o_pend      (o_pend),
        .o_ovf       (o_ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [CH_NUM-1:0] req, input logic en, input logic clr);
        i_req_pulse = req;
        i_enable    = en;
        i_clr_ovf   = clr;
    endtask

    // Advance n clock edges. Outputs are sampled 1ns after each edge, and every high o_pulse cycle is logged.
    task automatic stepCycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (o_pulse) begin
                pulse_cyc.push_back(cyc);
                pulse_id.push_back(int'(o_pulse_id));
            end
        end
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        stepCycle(2);
        i_rst_n = 1'b1;
        stepCycle(1);
        pulse_cyc.delete();
        pulse_id.delete();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pulse"}, 32'(o_pulse), 32'd0);
        checkOutput({tag, "_id"},    32'(o_pulse_id), 32'd0);
        checkOutput({tag, "_busy"},  32'(o_busy), 32'd0);
        checkOutput({tag, "_pend"},  32'(o_pend), 32'd0);
        checkOutput({tag, "_ovf"},   32'(o_ovf), 32'd0);
    endtask

    initial begin
        // Reset values
        doReset();
        checkResetState("rst");

        // Single request on ch2
        applyStimulus(4'b0100, 1'b1, 1'b0);
        stepCycle(1);
        e0 = cyc;
        checkOutput("single_pend_e0", 32'(o_pend), 32'd4);
        checkOutput("single_pulse_e0", 32'(o_pulse), 32'd0);
        checkOutput("single_busy_e0", 32'(o_busy), 32'd0);
        applyStimulus('0, 1'b1, 1'b0);
        stepCycle(1);
        checkOutput("single_pulse_e1", 32'(o_pulse), 32'd1);
        checkOutput("single_id_e1", 32'(o_pulse_id), 32'd2);
        checkOutput("single_pend_e1", 32'(o_pend), 32'd0);
        busy_cnt = o_busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            stepCycle(1);
            if (o_busy) busy_cnt++;
        end
        checkOutput("single_busy_cycles", 32'(busy_cnt), 32'd8);
        checkOutput("single_pulse_count", 32'(pulse_cyc.size()), 32'd1);
        if (pulse_cyc.size() > 0)
            checkOutput("single_rise_latency", 32'(pulse_cyc[0] - e0), 32'd1);
        checkOutput("single_id_hold", 32'(o_pulse_id), 32'd2);

        // Simultaneous requests on all channels
        doReset();
        applyStimulus(4'b1111, 1'b1, 1'b0);
        stepCycle(1);
        e0 = cyc;
        applyStimulus('0, 1'b1, 1'b0);
        stepCycle(40);
        checkOutput("all_pulse_count", 32'(pulse_cyc.size()), 32'd4);
        for (int i = 0; i < pulse_id.size() && i < 4; i++)
            checkOutput($sformatf("all_id_%0d", i), 32'(pulse_id[i]), 32'(i));
        if (pulse_cyc.size() > 0)
            checkOutput("all_first_latency", 32'(pulse_cyc[0] - e0), 32'd1);
        for (int i = 1; i < pulse_cyc.size() && i < 4; i++)
            checkOutput($sformatf("all_spacing_%0d", i), 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(GAP_CYC));
        checkOutput("all_busy_end", 32'(o_busy), 32'd0);

        // Saturation at CNT_W=2: five edges on ch1 with the arbiter disabled
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            stepCycle(1);
            applyStimulus('0, 1'b0, 1'b0);
            stepCycle(1);
        end
        checkOutput("sat_pend", 32'(o_pend), 32'd2);
        checkOutput("sat_ovf", 32'(o_ovf), 32'd2);
        checkOutput("sat_busy", 32'(o_busy), 32'd0);
        checkOutput("sat_no_pulse", 32'(pulse_cyc.size()), 32'd0);
        applyStimulus('0, 1'b1, 1'b0);
        stepCycle(40);
        checkOutput("sat_pulse_count", 32'(pulse_cyc.size()), 32'd3);
        for (int i = 0; i < pulse_id.size() && i < 3; i++)
            checkOutput($sformatf("sat_id_%0d", i), 32'(pulse_id[i]), 32'd1);
        checkOutput("sat_pend_drained", 32'(o_pend), 32'd0);
        checkOutput("sat_ovf_sticky", 32'(o_ovf), 32'd2);
        applyStimulus('0, 1'b1, 1'b1);
        stepCycle(1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("sat_ovf_cleared", 32'(o_ovf), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            stepCycle(1);
            applyStimulus('0, 1'b0, 1'b0);
            stepCycle(1);
        end
        checkOutput("sat_ovf_before_race", 32'(o_ovf), 32'd0);
        applyStimulus(4'b0010, 1'b0, 1'b1);
        stepCycle(1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("sat_set_beats_clr", 32'(o_ovf), 32'd2);

        // Edge on ch3 arriving in the same cycle ch3 is granted while saturated
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1000, 1'b0, 1'b0);
            stepCycle(1);
            applyStimulus('0, 1'b0, 1'b0);
            stepCycle(1);
        end
        checkOutput("race_pend_pre", 32'(o_pend), 32'd8);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        stepCycle(1);
        checkOutput("race_pulse", 32'(o_pulse), 32'd1);
        checkOutput("race_id", 32'(o_pulse_id), 32'd3);
        checkOutput("race_ovf", 32'(o_ovf), 32'd0);
        applyStimulus('0, 1'b1, 1'b0);
        stepCycle(40);
        checkOutput("race_pulse_count", 32'(pulse_cyc.size()), 32'd4);
        for (int i = 0; i < pulse_id.size() && i < 4; i++)
            checkOutput($sformatf("race_id_%0d", i), 32'(pulse_id[i]), 32'd3);
        if (pulse_cyc.size() > 1)
            checkOutput("race_followup_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(GAP_CYC));
        checkOutput("race_ovf_end", 32'(o_ovf), 32'd0);

        // Fairness: ch0 keeps re-requesting while ch1 has one request pending
        doReset();
        applyStimulus(4'b0011, 1'b1, 1'b0);
        stepCycle(1);
        for (int i = 0; i < 19; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0000 : 4'b0001, 1'b1, 1'b0);
            stepCycle(1);
        end
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("rr_pulse_count", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_id.size() > 2) begin
            checkOutput("rr_id_0", 32'(pulse_id[0]), 32'd0);
            checkOutput("rr_id_1", 32'(pulse_id[1]), 32'd1);
            checkOutput("rr_id_2", 32'(pulse_id[2]), 32'd0);
        end

        // Reset asserted in the middle of a GAP while ch2 is still pending
        doReset();
        applyStimulus(4'b0101, 1'b1, 1'b0);
        stepCycle(1);
        applyStimulus('0, 1'b1, 1'b0);
        stepCycle(4);
        checkOutput("midrst_busy_pre", 32'(o_busy), 32'd1);
        checkOutput("midrst_pend_pre", 32'(o_pend), 32'd4);
        i_rst_n = 1'b0;
        stepCycle(1);
        checkResetState("midrst");
        i_rst_n = 1'b1;
        pulse_cyc.delete();
        pulse_id.delete();
        stepCycle(30);
        checkOutput("midrst_no_pulse", 32'(pulse_cyc.size()), 32'd0);
        checkOutput("midrst_pend_post", 32'(o_pend), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmip_pulse_arb.md
# cmip_pulse_arb

Round-robin scheduler that shares a single toggle-based pulse clock-domain-crossing channel (cmip_pulse_sync) between several source-domain requesters. It does three things:
- Counts request edges per channel.
- Grants one pending channel at a time.
- Enforces a minimum spacing between issued pulses, so the downstream toggle synchronizer never merges or drops an event.

It sits in the source clock domain, directly in front of the sync instance's `i_pulse`. `o_pulse_id` is carried across the domain as quasi-static side data.

## Interface
- `CH_NUM`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(CH_NUM)`: width of `o_pulse_id`.
- `CNT_W`, 4: width of the per-channel pending counter; saturates at 2^CNT_W-1.
- `GAP_CYC`, 8: minimum `i_clk` cycles between consecutive `o_pulse` rising edges, ≥2. Must cover 3 destination-clock periods plus 1 source cycle.

Ports (name, direction, width, meaning):
- `i_clk` in 1: single clock; all logic on the rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_req_pulse` in CH_NUM: per-channel request; each 0→1 transition is one request.
- `i_enable` in 1: when low, no new grant starts; counting continues.
- `i_clr_ovf` in 1: single-cycle clear of all `o_ovf` bits.
- `o_pulse` out 1: one-cycle issue pulse to the sync channel.
- `o_pulse_id` out ID_W: granted channel; stable from the `o_pulse` rising edge until the next grant.
- `o_busy` out 1: FSM not in IDLE.
- `o_pend` out CH_NUM: per-channel pending count nonzero.
- `o_ovf` out CH_NUM: sticky; a request arrived while that counter was saturated.

## Operation
- **Edge detect:** `i_req_pulse` is registered into `req_d1`; `evt[k] = i_req_pulse[k] & ~req_d1[k]`.
- **Counters**, per channel:
  - `evt` alone: +1.
  - grant-decrement alone: -1.
  - `evt` and grant-decrement together: unchanged, and no overflow even if the counter is saturated.
  - `evt` at saturation without a decrement: count held, `o_ovf[k]` set.
  - `i_clr_ovf` together with a new overflow: the set wins.
- **Arbitration:** round-robin. The search starts at `(last_grant+1) mod CH_NUM` over channels with count≠0. `last_grant` resets to CH_NUM-1, so channel 0 is highest priority after reset.
- **FSM states:** IDLE, ISSUE, GAP.
  - **IDLE:** if `i_enable` and any count≠0, go to ISSUE. In the same cycle: latch the winner into `o_pulse_id`, decrement the winner's count, update `last_grant`.
  - **ISSUE:** `o_pulse`=1 for exactly one cycle. Load `gap_cnt` with GAP_CYC-2 and go to GAP.
  - **GAP:** decrement `gap_cnt`. At `gap_cnt`==0:
    - if `i_enable` and any count≠0, go directly to ISSUE with a new winner (same grant actions as IDLE);
    - otherwise go to IDLE.
- Deasserting `i_enable` never aborts an ISSUE or GAP already in progress.

## Timing
- **Reset values:** `o_pulse`=0, `o_pulse_id`=0, `o_busy`=0, `o_pend`=0, `o_ovf`=0. Internally: FSM=IDLE, all counters=0, `req_d1`=0, `last_grant`=CH_NUM-1, `gap_cnt`=0.
- **Reset mid-operation:** pending requests are discarded and any in-flight pulse is truncated to the cycle reset is applied. The downstream sync is reset from the same reset tree.
- **Latency:** a request sampled at edge E0 makes the count 1 at E0. The FSM goes to ISSUE at E1, so `o_pulse` is high over [E1,E2).
- **Spacing:** with continuous backlog, `o_pulse` rising edges are exactly GAP_CYC cycles apart. `o_pulse` is always low for ≥1 cycle between pulses.
- **Registered outputs:** all outputs come from registers; there is no combinational path from input to output.
- **Idle restart:** from IDLE, a request needs 1 extra cycle (the IDLE→ISSUE transition).

## Structure
- The shared package `cmip_pkg` holds:
  - the FSM state localparams (IDLE=2'd0, ISSUE=2'd1, GAP=2'd2);
  - the `GAP_CYC` legality check (GAP_CYC≥2).
- Sub-module `cmip_rr_pick`:
  - combinational;
  - inputs: request vector CH_NUM, pointer ID_W;
  - outputs: `valid`, `idx`.
- Counters, FSM and outputs stay in `cmip_pulse_arb`.

## Test plan
- **Single request:** CH_NUM=4, GAP_CYC=8; one rising edge on ch2.
  - `o_pulse` for exactly 1 cycle, rising at E1.
  - `o_pulse_id`=2; `o_busy` high for 8 cycles; `o_pend`=0 afterwards.
- **Simultaneous requests:** edges on ch0..ch3 in the same cycle.
  - Grants in order 0,1,2,3.
  - `o_pulse` rising edges 8 cycles apart; total 4 pulses.
- **Saturation:** CNT_W=2; 5 edges on ch1 while `i_enable`=0.
  - Count=3 and `o_ovf[1]`=1.
  - Raise `i_enable`: exactly 3 pulses with id=1.
  - `i_clr_ovf` clears `o_ovf`.
- **Same-cycle edge and decrement:** a ch3 edge in the same cycle ch3 is granted.
  - Count holds at its value, with no overflow.
  - A follow-up pulse id=3 issues GAP_CYC later.
- **Round-robin fairness:** ch0 re-requests continuously while ch1 has 1 pending.
  - Order 0,1,0,…; ch1 is never starved.
- **Reset mid-GAP:** assert `i_rst_n`=0 with 2 pending.
  - All outputs reset values the next edge.
  - No pulse after release without new edges.
